// File: rtl/alu_operand_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_arbiter
// Description : Round-robin arbiter granting one of two requesters the ALU
//               operand path. A grant latches the winner's operands onto A/B
//               and sequences IDLE -> SETUP -> ENABLE (HOLD_CYCLES) -> RELEASE.
//               All outputs are registered.
// Ports       : clk, rst_n (async, active-low)
//               arb_en         - global permit, gates new grants only
//               req0/a0/b0     - requester 0 request and operands
//               req1/a1/b1     - requester 1 request and operands
//               gnt0/gnt1      - ownership of the operand path
//               A/B            - latched operands
//               en             - operand gate enable
//               busy           - high in any state other than IDLE
//               done/done_id   - one-cycle completion pulse and served id
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ENABLE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // The down-counter reaches zero on the last enable cycle.
    localparam logic [3:0] c_hold_load = 4'(HOLD_CYCLES - 1);

    state_t     state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic       last_id_q, last_id_d;
    logic       cur_id_q,  cur_id_d;
    logic       gnt0_q,    gnt0_d;
    logic       gnt1_q,    gnt1_d;
    logic [3:0] a_q,       a_d;
    logic [3:0] b_q,       b_d;
    logic       en_q,      en_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic       done_id_q, done_id_d;
    logic       w_win_id;

    // Lone requester wins; on a tie the requester not served last wins.
    assign w_win_id = (req0 && req1) ? ~last_id_q : req1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        cur_id_d  = cur_id_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        a_d       = a_q;
        b_d       = b_q;
        en_d      = en_q;
        done_d    = 1'b0;
        done_id_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_en && (req0 || req1)) begin
                    state_d  = ST_SETUP;
                    cur_id_d = w_win_id;
                    gnt0_d   = ~w_win_id;
                    gnt1_d   = w_win_id;
                    a_d      = w_win_id ? a1 : a0;
                    b_d      = w_win_id ? b1 : b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ENABLE;
                en_d    = 1'b1;
                cnt_d   = c_hold_load;
            end
            ST_ENABLE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RELEASE;
                    en_d      = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = cur_id_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RELEASE: begin
                state_d   = ST_IDLE;
                gnt0_d    = 1'b0;
                gnt1_d    = 1'b0;
                last_id_d = cur_id_q;
            end
            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            last_id_q <= 1'b1;
            cur_id_q  <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
            cur_id_q  <= cur_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign A       = a_q;
    assign B       = b_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule
`default_nettype wire

// File: doc/alu_operand_arbiter.md
ALU_OPERAND_ARBITER -- requirements
Module: alu_operand_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 2, the number of cycles en is held high per grant (legal range 1..15).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, clock and reset first:
- clk  input  1  single clock, rising edge
- rst_n  input  1  async active-low reset
- arb_en  input  1  global permit; low blocks new grants only
- req0  input  1  requester 0 request, level
- a0  input  4  requester 0 operand A
- b0  input  4  requester 0 operand B
- req1  input  1  requester 1 request, level
- a1  input  4  requester 1 operand A
- b1  input  4  requester 1 operand B
- gnt0  output  1  requester 0 owns the operand path
- gnt1  output  1  requester 1 owns the operand path
- A  output  4  operand A driven to the enable gate
- B  output  4  operand B driven to the enable gate
- en  output  1  enable to the operand gate
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- done_id  output  1  requester served; valid only while done=1

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ENABLE and RELEASE; all outputs SHALL be registered.
REQ-005 IDLE: the FSM SHALL go to SETUP at the next edge if arb_en=1 and (req0|req1) is high; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin on a last_id register.
- Only one request high: that requester wins.
- Both requests high: the requester other than last_id wins.
REQ-007 On the IDLE->SETUP edge the block SHALL:
- latch the winner's a/b into A/B;
- set the winner's gnt;
- record the winner's id.
A and B SHALL then hold constant until the next grant.
REQ-008 SETUP SHALL last exactly 1 cycle with en=0, then go to ENABLE.
REQ-009 ENABLE SHALL hold en=1 for exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter loaded with HOLD_CYCLES-1, then go to RELEASE.
REQ-010 RELEASE SHALL last 1 cycle:
- en=0, done=1, done_id=recorded id, gnt still high;
- last_id SHALL update to the recorded id at the exit edge;
- the FSM SHALL then return to IDLE with gnt0=gnt1=0.
REQ-011 Latency: a request sampled in IDLE at edge k SHALL give:
- gnt, A and B valid from edge k;
- en high from edge k+1 through edge k+HOLD_CYCLES;
- done high for the cycle following edge k+1+HOLD_CYCLES;
- IDLE from edge k+2+HOLD_CYCLES.
Back-to-back service period SHALL be HOLD_CYCLES+3 cycles.
REQ-012 Once granted, a transaction SHALL complete unchanged in these cases:
- the requester drops req;
- a, b or the other req change;
- arb_en falls.
REQ-013 A request still high in IDLE after its own done SHALL be eligible again; under continuous dual requests, grants SHALL alternate 0,1,0,1...
REQ-014 At most one of gnt0/gnt1 SHALL be high in any cycle; en=1 SHALL imply exactly one gnt high.
REQ-015 busy SHALL be low only in IDLE.

Reset
REQ-016 While rst_n=0, regardless of clk, the block SHALL:
- be in state IDLE;
- drive gnt0=gnt1=0, en=0, busy=0, done=0, done_id=0, A=0, B=0;
- set last_id=1 and counter=0.
REQ-017 Reset asserted mid-transaction SHALL abort it immediately, with no done pulse.
REQ-018 After rst_n deasserts, the first arbitration SHALL be at the first rising edge with rst_n=1.
REQ-019 Because last_id resets to 1, simultaneous requests after reset SHALL grant requester 0 first.

Verification
REQ-020 Single request, HOLD_CYCLES=2:
- stimulus: req0=1, a0=4'b1010, b0=4'b0101;
- response: gnt0=1, A=1010, B=0101 after 1 edge; en high for 2 cycles; done=1 with done_id=0 one cycle later; IDLE after 5 edges total.
REQ-021 Simultaneous requests after reset:
- stimulus: req0=req1=1 held;
- response: grant order 0,1,0; done_id sequence 0,1,0; each grant spaced 5 cycles apart; never both gnt high.
REQ-022 Operand stability:
- stimulus: req1=1 with a1=4'b1111, b1=4'b0001; change a1 to 0000 during ENABLE;
- response: A stays 1111 until done.
REQ-023 arb_en gating:
- stimulus: arb_en=0, req0=1 for 4 cycles, then arb_en=1;
- response: no gnt, en or busy while arb_en=0; grant on the first edge after arb_en=1.
- stimulus: drop arb_en during ENABLE;
- response: the transaction still completes with done=1.
REQ-024 Reset mid-operation:
- stimulus: rst_n=0 asynchronously in the second ENABLE cycle;
- response: en, gnt, A and B go to 0 immediately with no done pulse; after release with req1=1 only, gnt1 is granted.
REQ-025 Parameter sweep:
- HOLD_CYCLES=1: en high exactly 1 cycle.
- HOLD_CYCLES=15: en high exactly 15 cycles, period 18.
